tie_cfg_bank: RTL

- Parametrised successor to the fixed tie-high/tie-low cells: a bank of WIDTH constant-driving outputs.
- Each output powers up at a per-bit default and can be reprogrammed at runtime through a serial shift/commit interface.
- Provides a lock mechanism so values become static ties until the next reset.
- Used by generator-level analog macros (trim/config straps) in place of hard tie cells.

---
 rtl/tie_cfg_pkg.sv | 27 ++
 rtl/tie_cfg_shreg.sv | 72 +++++++
 rtl/tie_cfg_bank.sv | 126 ++++++++++++
 3 files changed

// File: rtl/tie_cfg_pkg.sv
// Shared types and helpers for the tie_cfg_bank configurable tie-cell bank.
// Honours TIE_CFG_PARITY_EN: when defined, frames carry a trailing even-parity bit.
package tie_cfg_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    READY = 2'd2,
    LOCK  = 2'd3
  } state_t;

`ifdef TIE_CFG_PARITY_EN
  localparam bit PARITY_EN = 1'b1;
`else
  localparam bit PARITY_EN = 1'b0;
`endif

  // Frame length in serial bits: data bits plus the optional parity bit.
  function automatic int frameLen(input int width);
    return PARITY_EN ? width + 1 : width;
  endfunction

  function automatic logic evenParity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/tie_cfg_shreg.sv
// Shadow shift register, frame bit counter and FULL detection for tie_cfg_bank.
// Honours TIE_CFG_PARITY_EN: the last frame bit lands in a separate parity flop.
module tie_cfg_shreg
  import tie_cfg_pkg::*;
#(
  parameter int             WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}},
  parameter int             FRAME_LEN   = WIDTH,
  parameter int             CNT_W       = $clog2(FRAME_LEN + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_shift,
  input  logic             i_clear,
  input  logic             i_sdi,
  output logic [WIDTH-1:0] o_shadow,
  output logic             o_full,
  output logic             o_lastBit,
  output logic             o_parityOk
);

  logic [WIDTH-1:0] r_shadow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] w_shiftNext;
  logic             w_full;
  logic             w_dataPhase;

  assign w_full      = (r_cnt == CNT_W'(FRAME_LEN));
  assign w_dataPhase = (r_cnt < CNT_W'(WIDTH));

  generate
    if (WIDTH == 1) begin : g_oneBit
      assign w_shiftNext = i_sdi;
    end else begin : g_multiBit
      assign w_shiftNext = {r_shadow[WIDTH-2:0], i_sdi};
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_shadow <= RESET_VALUE;
      r_cnt    <= '0;
    end else if (i_shift && !w_full) begin
      if (w_dataPhase) begin
        r_shadow <= w_shiftNext;
      end
      r_cnt <= r_cnt + 1'b1;
    end
  end

`ifdef TIE_CFG_PARITY_EN
  logic r_parity;

  // Only the bit following the last data bit is captured as parity.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clear) begin
      r_parity <= 1'b0;
    end else if (i_shift && !w_full && !w_dataPhase) begin
      r_parity <= i_sdi;
    end
  end

  assign o_parityOk = (evenParity(64'(r_shadow)) == r_parity);
`else
  assign o_parityOk = 1'b1;
`endif

  assign o_shadow  = r_shadow;
  assign o_full    = w_full;
  assign o_lastBit = (r_cnt == CNT_W'(FRAME_LEN - 1));

endmodule

// File: rtl/tie_cfg_bank.sv
// Bank of WIDTH runtime-programmable tie outputs with serial load, commit and lock.
// Honours TIE_CFG_PARITY_EN: commits are accepted only for frames with good even parity.
module tie_cfg_bank
  import tie_cfg_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b1}}
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             SDI,
  input  logic             SEN,
  input  logic             COMMIT,
  input  logic             LOCK_REQ,
  output logic [WIDTH-1:0] Y,
  output logic             FULL,
  output logic             DONE,
  output logic             ERR,
  output logic             OVF,
  output logic             LOCKED
);

  localparam int FRAME_LEN = frameLen(WIDTH);
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_y;
  logic             r_done;
  logic             r_err;
  logic             r_ovf;

  logic [WIDTH-1:0] w_shadow;
  logic             w_full;
  logic             w_lastBit;
  logic             w_parityOk;
  logic             w_shiftEn;
  logic             w_clear;
  logic             w_loadY;
  logic             w_doneNext;
  logic             w_errNext;
  logic             w_ovfSet;
  logic             w_ovfClr;

  tie_cfg_shreg #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE),
    .FRAME_LEN   (FRAME_LEN),
    .CNT_W       (CNT_W)
  ) u_shreg (
    .i_clk      (CLK),
    .i_rst      (RST),
    .i_shift    (w_shiftEn),
    .i_clear    (w_clear),
    .i_sdi      (SDI),
    .o_shadow   (w_shadow),
    .o_full     (w_full),
    .o_lastBit  (w_lastBit),
    .o_parityOk (w_parityOk)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_y     <= RESET_VALUE;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_done  <= w_doneNext;
      r_err   <= w_errNext;
      if (w_loadY) begin
        r_y <= w_shadow;
      end
      if (w_ovfClr) begin
        r_ovf <= 1'b0;
      end else if (w_ovfSet) begin
        r_ovf <= 1'b1;
      end
    end
  end

  // Priority within an unlocked state: LOCK_REQ, then COMMIT, then SEN.
  always_comb begin
    w_nextState = r_state;
    w_shiftEn   = 1'b0;
    w_clear     = 1'b0;
    w_loadY     = 1'b0;
    w_doneNext  = 1'b0;
    w_errNext   = 1'b0;
    w_ovfSet    = 1'b0;
    w_ovfClr    = 1'b0;
    if (r_state != LOCK) begin
      if (LOCK_REQ) begin
        w_nextState = LOCK;
        w_clear     = 1'b1;
      end else if (COMMIT) begin
        w_nextState = IDLE;
        w_clear     = 1'b1;
        if (r_state == READY && w_parityOk) begin
          w_loadY    = 1'b1;
          w_doneNext = 1'b1;
          w_ovfClr   = 1'b1;
        end else begin
          w_errNext = 1'b1;
        end
      end else if (SEN) begin
        if (r_state == READY) begin
          w_ovfSet = 1'b1;
        end else begin
          w_shiftEn   = 1'b1;
          w_nextState = w_lastBit ? READY : SHIFT;
        end
      end
    end
  end

  assign Y      = r_y;
  assign FULL   = w_full;
  assign DONE   = r_done;
  assign ERR    = r_err;
  assign OVF    = r_ovf;
  assign LOCKED = (r_state == LOCK);

endmodule
